regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback sources (ALU, mult/div unit, load path) using a round-robin handshake.
- Drives the regfile's ctrl_writeEnable, ctrl_writeReg and data_writeReg from a registered output stage.
- Keeps a per-register pending-write scoreboard, set at instruction issue and cleared at writeback, so the decode stage can stall on RAW hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width; register count is 2**ADDR_W

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a writeback pending
- req_reg  in  NUM_REQ*ADDR_W  destination index, requester i at slice [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  write data, requester i at slice [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs on valid&ready
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_reg  in  ADDR_W  destination register of the issuing instruction
- rd_regA  in  ADDR_W  decode source register A
- rd_regB  in  ADDR_W  decode source register B
- hazard  out  1  rd_regA or rd_regB has a pending write
- busy_mask  out  2**ADDR_W  scoreboard state
- ctrl_writeEnable  out  1  to the regfile write enable
- ctrl_writeReg  out  ADDR_W  to the regfile write index
- data_writeReg  out  DATA_W  to the regfile write data
- wb_err  out  1  sticky: a writeback arrived for a non-busy, non-zero register

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - busy_mask=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, wb_err=0
  - round-robin pointer last=NUM_REQ-1, so requester 0 has highest priority first
- Arbitration is combinational each cycle:
  - Scan i = last+1, last+2, ... modulo NUM_REQ; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - All other ready bits are 0. With no valid requests, req_ready=0.
  - The write port never back-pressures, so a valid request is granted within NUM_REQ cycles (starvation-free).
- On a transfer (valid&ready on index g) at edge N:
  - last<=g
  - ctrl_writeReg<=req_reg[g], data_writeReg<=req_data[g]
  - ctrl_writeEnable<=(req_reg[g]!=0); writes to r0 are accepted and acknowledged but never written
- With no transfer: ctrl_writeEnable<=0. ctrl_writeReg and data_writeReg hold their values.
- Latency: the regfile sees the write exactly 1 cycle after the handshake and commits it at the following edge. Back-to-back transfers give one write per cycle.
- Scoreboard, updated at the same edge as the handshake:
  - clear: busy[req_reg[g]]<=0 on a transfer
  - set: busy[issue_reg]<=1 when issue_valid and issue_reg!=0
  - same register set and cleared in one cycle: set wins (newer producer)
  - busy[0] is always 0
- wb_err<=1 on a transfer with req_reg[g]!=0 and busy[req_reg[g]]=0. It is cleared only by reset.
- hazard is combinational from registered state: (rd_regA!=0 & busy[rd_regA]) | (rd_regB!=0 & busy[rd_regB]).
  - No bypass from a same-cycle clear: a register cleared at edge N stops raising hazard after edge N.
- Reset asserted mid-operation: the in-flight output write is dropped (enable forced 0) and all pending bits are lost. Requesters must also be reset.
- Issuing the same register twice before writeback: a single bit tracks it, so the first writeback clears it. The issue logic must not issue a second producer to a busy register; this block does not check that.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32
  - requester index constants WB_ALU=0, WB_MULTDIV=1, WB_LOAD=2
- One sub-module, rr_arbiter (parameter N):
  - inputs: req vector, last pointer
  - outputs: one-hot grant, encoded grant index
  - purely combinational; it is reused by future memory-port sharing.
- The scoreboard stays inline.

Test Plan:
- After reset, all three valid to regs 3/4/5 with data A/B/C:
  - ready grants 0, 1, 2 on consecutive cycles
  - regfile sees (3,A), (4,B), (5,C) with writeEnable=1, each one cycle after its grant
- Requesters 0 and 2 held valid continuously: grants alternate 0, 2, 0, 2; requester 1 idle is never granted.
- issue_reg=7 at cycle 0; rd_regA=7: hazard=1 from cycle 1. Writeback to 7 at cycle 4: busy[7]=0 and hazard=0 from cycle 5.
- Same cycle, issue_reg=9 and writeback to 9 (busy[9] already 1) -> busy[9] stays 1 and wb_err stays 0.
- Writeback to r0 with data 0xFFFFFFFF -> ready=1, ctrl_writeEnable stays 0, busy_mask unchanged. Writeback to non-busy r12 -> wb_err=1 and it stays 1.
- Reset pulsed low between a grant and its output cycle -> ctrl_writeEnable=0 immediately, busy_mask=0, hazard=0, next grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared regfile geometry and writeback source indices
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam int WB_ALU     = 0;
  localparam int WB_MULTDIV = 1;
  localparam int WB_LOAD    = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - combinational round-robin grant starting after last winner
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grantIdx
);

  int  idx;
  logic found;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grantIdx   = IDX_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin regfile write-port sharing with pending-write scoreboard
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_reg,
  input  logic [ADDR_W-1:0]         rd_regA,
  input  logic [ADDR_W-1:0]         rd_regB,
  output logic                      hazard,
  output logic [2**ADDR_W-1:0]      busy_mask,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic                      wb_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    grantIdx;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  logic [ADDR_W-1:0]   wbReg;
  logic [DATA_W-1:0]   wbData;
  logic [2**ADDR_W-1:0] busy;
  logic [2**ADDR_W-1:0] busyNext;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) arb (
    .req      (req_valid),
    .last     (last),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign wbReg     = req_reg[grantIdx*ADDR_W +: ADDR_W];
  assign wbData    = req_data[grantIdx*DATA_W +: DATA_W];

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    busyNext = busy;
    if (xfer) busyNext[wbReg] = 1'b0;
    if (issue_valid && issue_reg != '0) busyNext[issue_reg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last             <= IDX_W'(NUM_REQ - 1);
      busy             <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      wb_err           <= 1'b0;
    end else begin
      busy <= busyNext;
      if (xfer) begin
        last             <= grantIdx;
        ctrl_writeReg    <= wbReg;
        data_writeReg    <= wbData;
        ctrl_writeEnable <= (wbReg != '0);
        if (wbReg != '0 && !busy[wbReg]) wb_err <= 1'b1;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
    end
  end

  assign busy_mask = busy;
  assign hazard    = (rd_regA != '0 && busy[rd_regA]) || (rd_regB != '0 && busy[rd_regB]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_reg;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             issue_valid;
  logic [AW-1:0]    issue_reg;
  logic [AW-1:0]    rd_regA;
  logic [AW-1:0]    rd_regB;
  logic             hazard;
  logic [31:0]      busy_mask;
  logic             ctrl_writeEnable;
  logic [AW-1:0]    ctrl_writeReg;
  logic [DW-1:0]    data_writeReg;
  logic             wb_err;

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .issue_valid      (issue_valid),
    .issue_reg        (issue_reg),
    .rd_regA          (rd_regA),
    .rd_regB          (rd_regB),
    .hazard           (hazard),
    .busy_mask        (busy_mask),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_err           (wb_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int tests = 0;
  int failed = 0;

  int          mLast;
  logic [4:0]  mReg;
  logic [31:0] mData;
  logic [31:0] mBusy;
  logic        mErr;

  task automatic model_reset();
    mLast = NR - 1;
    mReg  = '0;
    mData = '0;
    mBusy = '0;
    mErr  = 1'b0;
    sbq.delete();
  endtask

  // Applies one cycle of stimulus and pushes the state expected after the next edge.
  task automatic drive(input logic [NR-1:0] v, input logic [NR*AW-1:0] r,
                       input logic [NR*DW-1:0] d, input logic iv, input logic [4:0] ir);
    exp_t e;
    int g;
    logic [4:0] wr;
    req_valid   = v;
    req_reg     = r;
    req_data    = d;
    issue_valid = iv;
    issue_reg   = ir;
    g = -1;
    for (int k = 1; k <= NR; k++) begin
      if (g < 0 && v[(mLast + k) % NR]) g = (mLast + k) % NR;
    end
    e.we = 1'b0;
    if (g >= 0) begin
      wr    = r[g*AW +: AW];
      mLast = g;
      mReg  = wr;
      mData = d[g*DW +: DW];
      e.we  = (wr != 0);
      if (wr != 0 && !mBusy[wr]) mErr = 1'b1;
      mBusy[wr] = 1'b0;
    end
    if (iv && ir != 0) mBusy[ir] = 1'b1;
    mBusy[0] = 1'b0;
    e.r    = mReg;
    e.d    = mData;
    e.busy = mBusy;
    e.err  = mErr;
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    drive('0, '0, '0, 1'b0, 5'd0);
  endtask

  always @(posedge clock) begin
    #1;
    if (reset && sbq.size() > 0) begin
      me = sbq.pop_front();
      tests++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {me.we, me.r, me.d}) begin
        failed++;
        $display("FAIL wb_port: got we=%0b reg=%0d data=%h, expected we=%0b reg=%0d data=%h",
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, me.we, me.r, me.d);
      end
      tests++;
      if (busy_mask !== me.busy) begin
        failed++;
        $display("FAIL busy_mask: got %h expected %h", busy_mask, me.busy);
      end
      tests++;
      if (wb_err !== me.err) begin
        failed++;
        $display("FAIL wb_err: got %0b expected %0b", wb_err, me.err);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    req_valid = '0; req_reg = '0; req_data = '0;
    issue_valid = 1'b0; issue_reg = '0; rd_regA = '0; rd_regB = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask, wb_err, hazard} !== '0) begin
      failed++;
      $display("FAIL reset_state: got we=%0b reg=%0d data=%h busy=%h err=%0b hazard=%0b, expected all 0",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, busy_mask, wb_err, hazard);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] vseq [3];
    logic [NR-1:0] gexp [3];
    vseq[0] = 3'b111; vseq[1] = 3'b110; vseq[2] = 3'b100;
    gexp[0] = 3'b001; gexp[1] = 3'b010; gexp[2] = 3'b100;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clock);
      drive('0, '0, '0, 1'b1, 5'(i));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      drive(vseq[c], {5'd5, 5'd4, 5'd3}, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b0, 5'd0);
      #1;
      tests++;
      if (req_ready !== gexp[c]) begin
        failed++;
        $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, gexp[c]);
      end
    end
    idle();
  endtask

  task automatic test_alternate();
    logic [NR-1:0] want;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      drive(3'b101, '0, {32'h2000_0000 + 32'(c), 32'h0, 32'h1000_0000 + 32'(c)}, 1'b0, 5'd0);
      want = (c % 2 == 0) ? 3'b001 : 3'b100;
      #1;
      tests++;
      if (req_ready !== want) begin
        failed++;
        $display("FAIL alt_grant%0d: got %b expected %b", c, req_ready, want);
      end
    end
    idle();
  endtask

  task automatic test_hazard();
    logic hexp;
    rd_regA = 5'd7;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 0)      drive('0, '0, '0, 1'b1, 5'd7);
      else if (c == 4) drive(3'b001, {10'd0, 5'd7}, {64'd0, 32'h7777_7777}, 1'b0, 5'd0);
      else             drive('0, '0, '0, 1'b0, 5'd0);
      hexp = (c >= 1 && c <= 4);
      #1;
      tests++;
      if (hazard !== hexp) begin
        failed++;
        $display("FAIL hazard_c%0d: got %0b expected %0b", c, hazard, hexp);
      end
    end
    rd_regA = '0;
  endtask

  task automatic test_same_cycle();
    @(negedge clock);
    drive('0, '0, '0, 1'b1, 5'd9);
    @(negedge clock);
    drive(3'b010, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h9999_0009, 32'd0}, 1'b1, 5'd9);
    @(posedge clock);
    #1;
    tests++;
    if (busy_mask[9] !== 1'b1 || wb_err !== 1'b0) begin
      failed++;
      $display("FAIL same_cycle: got busy9=%0b err=%0b expected busy9=1 err=0", busy_mask[9], wb_err);
    end
    idle();
  endtask

  task automatic test_r0_and_err();
    @(negedge clock);
    drive(3'b100, '0, {32'hFFFF_FFFF, 64'd0}, 1'b0, 5'd0);
    #1;
    tests++;
    if (req_ready !== 3'b100) begin
      failed++;
      $display("FAIL r0_ready: got %b expected 100", req_ready);
    end
    @(negedge clock);
    drive(3'b001, {10'd0, 5'd12}, {64'd0, 32'h1212_1212}, 1'b0, 5'd0);
    repeat (3) idle();
    @(posedge clock);
    #1;
    tests++;
    if (wb_err !== 1'b1) begin
      failed++;
      $display("FAIL err_sticky: got %0b expected 1", wb_err);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clock);
    drive('0, '0, '0, 1'b1, 5'd20);
    @(negedge clock);
    drive(3'b010, {5'd0, 5'd20, 5'd0}, {32'd0, 32'h2020_2020, 32'd0}, 1'b0, 5'd0);
    rd_regA = 5'd20;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({ctrl_writeEnable, busy_mask, hazard, wb_err} !== '0) begin
      failed++;
      $display("FAIL reset_midop: got we=%0b busy=%h hazard=%0b err=%0b expected all 0",
               ctrl_writeEnable, busy_mask, hazard, wb_err);
    end
    model_reset();
    rd_regA = '0;
    @(negedge clock);
    reset = 1'b1;
    drive(3'b111, '0, '0, 1'b0, 5'd0);
    #1;
    tests++;
    if (req_ready !== 3'b001) begin
      failed++;
      $display("FAIL post_reset_grant: got %b expected 001", req_ready);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_hazard();
    test_same_cycle();
    test_r0_and_err();
    test_reset_midop();
    repeat (2) @(posedge clock);
    #2;
    tests++;
    if (sbq.size() != 0) begin
      failed++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
